// File: rtl/disp_view_sched.sv
`timescale 1ns/1ps
// Display-view scheduler: arbitrates MODE button, alarm and inactivity timeout
// onto the 7-segment word select, and produces the blink enable.
module disp_view_sched #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned DEB_MS     = 20,
  parameter int unsigned TIMEOUT_MS = 10000,
  parameter int unsigned BLINK_MS   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       alarm_req,
  input  logic       edit_en,
  output logic [1:0] sel_d,
  output logic       blink,
  output logic       alarm_ack,
  output logic       view_chg
);

  localparam int unsigned PW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int unsigned DW = (DEB_MS > 0)     ? $clog2(DEB_MS + 1) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_MS + 1);
  localparam int unsigned BW = (BLINK_MS > 1)   ? $clog2(BLINK_MS)   : 1;

  typedef enum logic [2:0] {ST_T, ST_D, ST_A, ST_S, ST_ALM} state_t;

  function automatic logic [1:0] sel_of(input state_t s);
    logic [1:0] r;
    r = 2'b00;
    case (s)
      ST_D:    r = 2'b01;
      ST_A:    r = 2'b10;
      ST_S:    r = 2'b11;
      ST_ALM:  r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic state_t next_view(input state_t s);
    state_t r;
    r = ST_T;
    case (s)
      ST_T:    r = ST_D;
      ST_D:    r = ST_A;
      ST_A:    r = ST_S;
      default: r = ST_T;
    endcase
    return r;
  endfunction

  // 1 ms tick prescaler
  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Button synchronizer and debounce; counts ticks while the synced level disagrees
  logic          btn_s1, btn_s2, btn_acc;
  logic [DW-1:0] deb_cnt;
  logic          deb_done, press;

  assign deb_done = tick && (btn_s2 != btn_acc) && (deb_cnt == DW'(DEB_MS - 1));
  assign press    = deb_done && btn_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      btn_acc <= 1'b0;
      deb_cnt <= '0;
    end else begin
      btn_s1 <= btn_mode;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_acc) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        btn_acc <= btn_s2;
        deb_cnt <= '0;
      end else if (tick) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  state_t        state, state_n;
  logic          armed, ack_c, in_view, to_hit;
  logic [TW-1:0] to_cnt;

  assign in_view = (state == ST_D) || (state == ST_A) || (state == ST_S);
  assign to_hit  = (to_cnt == TW'(TIMEOUT_MS)) && !edit_en;

  // Next-state decode: alarm > press > timeout
  always_comb begin
    state_n = state;
    ack_c   = 1'b0;
    if (state == ST_ALM) begin
      if (press) begin
        state_n = ST_T;
        ack_c   = 1'b1;
      end else if (!alarm_req) begin
        state_n = ST_T;
      end
    end else if (alarm_req && armed) begin
      state_n = ST_ALM;
    end else if (press) begin
      state_n = next_view(state);
    end else if (in_view && to_hit) begin
      state_n = ST_T;
    end
  end

  // Inactivity counter, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (press || edit_en || (state_n != state)) begin
      to_cnt <= '0;
    end else if (tick && in_view && (to_cnt != TW'(TIMEOUT_MS))) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Blink phase generator, restarted visible on alarm entry or edit start
  logic          phase, phase_n, edit_q;
  logic [BW-1:0] bl_cnt, bl_cnt_n;

  always_comb begin
    phase_n  = phase;
    bl_cnt_n = bl_cnt;
    if (((state_n == ST_ALM) && (state != ST_ALM)) || (edit_en && !edit_q)) begin
      phase_n  = 1'b1;
      bl_cnt_n = '0;
    end else if (tick) begin
      if (bl_cnt == BW'(BLINK_MS - 1)) begin
        bl_cnt_n = '0;
        phase_n  = !phase;
      end else begin
        bl_cnt_n = bl_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= 1'b1;
      bl_cnt <= '0;
      edit_q <= 1'b0;
    end else begin
      phase  <= phase_n;
      bl_cnt <= bl_cnt_n;
      edit_q <= edit_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_T;
      sel_d     <= 2'b00;
      view_chg  <= 1'b0;
      alarm_ack <= 1'b0;
      armed     <= 1'b1;
      blink     <= 1'b1;
    end else begin
      state     <= state_n;
      sel_d     <= sel_of(state_n);
      view_chg  <= (sel_of(state_n) != sel_d);
      alarm_ack <= ack_c;
      if (ack_c)           armed <= 1'b0;
      else if (!alarm_req) armed <= 1'b1;
      blink     <= ((state_n == ST_ALM) || edit_en) ? phase_n : 1'b1;
    end
  end

endmodule

// File: tb/tb_disp_view_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for disp_view_sched: expected views queued at stimulus time,
// popped on every view_chg pulse.
module tb_disp_view_sched;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned DEB_MS     = 3;
  localparam int unsigned TIMEOUT_MS = 20;
  localparam int unsigned BLINK_MS   = 5;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       btn_mode  = 1'b0;
  logic       alarm_req = 1'b0;
  logic       edit_en   = 1'b0;
  logic [1:0] sel_d;
  logic       blink, alarm_ack, view_chg;

  disp_view_sched #(
    .TICK_DIV  (TICK_DIV),
    .DEB_MS    (DEB_MS),
    .TIMEOUT_MS(TIMEOUT_MS),
    .BLINK_MS  (BLINK_MS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .alarm_req(alarm_req),
    .edit_en  (edit_en),
    .sel_d    (sel_d),
    .blink    (blink),
    .alarm_ack(alarm_ack),
    .view_chg (view_chg)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         ack_seen = 0;
  int         exp_ack = 0;
  int         last_chg_cyc = 0;
  logic [1:0] prev_sel = 2'b00;
  logic [1:0] exp_q[$];

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the button path, used only to time the collision case
  int unsigned m_presc, m_cnt;
  logic        m_s1, m_s2, m_acc, m_tick, m_done, m_press;

  assign m_tick  = (m_presc == TICK_DIV - 1);
  assign m_done  = m_tick && (m_s2 != m_acc) && (m_cnt == DEB_MS - 1);
  assign m_press = m_done && m_s2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_presc <= 0;
      m_cnt   <= 0;
      m_s1    <= 1'b0;
      m_s2    <= 1'b0;
      m_acc   <= 1'b0;
    end else begin
      m_presc <= m_tick ? 0 : m_presc + 1;
      m_s1    <= btn_mode;
      m_s2    <= m_s1;
      if (m_s2 == m_acc) m_cnt <= 0;
      else if (m_done) begin
        m_acc <= m_s2;
        m_cnt <= 0;
      end else if (m_tick) m_cnt <= m_cnt + 1;
    end
  end

  // Output monitor: pops the scoreboard on each view_chg
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sel = 2'b00;
      end else begin
        if (view_chg) begin
          last_chg_cyc = cyc;
          chk_val("chg_real", 32'(sel_d != prev_sel), 1);
          if (exp_q.size() == 0) chk_val("unexp_view_chg", 32'(view_chg), 0);
          else                   chk_val("view_sel", 32'(sel_d), 32'(exp_q.pop_front()));
        end
        if (sel_d != prev_sel) chk_val("chg_pulse", 32'(view_chg), 1);
        if (alarm_ack) begin
          ack_seen++;
          chk_val("ack_with_chg", 32'(view_chg), 1);
        end
        prev_sel = sel_d;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input int hold);
    btn_mode = 1'b1;
    wait_cyc(hold);
    btn_mode = 1'b0;
    wait_cyc(20);
  endtask

  task automatic wait_drain(input int max_cyc, input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk_val(tag, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, t0, dt;

    // Reset
    #2 rst_n = 1'b0;
    wait_cyc(3);
    chk_val("rst_sel", 32'(sel_d), 0);
    chk_val("rst_blink", 32'(blink), 1);
    chk_val("rst_chg", 32'(view_chg), 0);
    chk_val("rst_ack", 32'(alarm_ack), 0);
    rst_n = 1'b1;
    wait_cyc(5);
    chk_val("rel_sel", 32'(sel_d), 0);
    chk_val("rel_blink", 32'(blink), 1);

    // Cycle views with four clean presses
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(2'((i + 1) % 4));
      press_btn(20);
    end
    wait_drain(40, "cycle_drain");
    chk_val("cycle_end_sel", 32'(sel_d), 0);

    // Short glitch must be ignored
    btn_mode = 1'b1;
    wait_cyc(6);
    btn_mode = 1'b0;
    wait_cyc(30);
    chk_val("glitch_sel", 32'(sel_d), 0);

    // Inactivity timeout from view 01
    exp_q.push_back(2'd1);
    press_btn(20);
    wait_drain(10, "to_enter");
    t0 = last_chg_cyc;
    exp_q.push_back(2'd0);
    wait_drain(150, "to_return");
    dt = last_chg_cyc - t0;
    chk_val("to_latency_ok", 32'(dt >= 78 && dt <= 81), 1);

    // Edit mode suppresses timeout
    edit_en = 1'b1;
    exp_q.push_back(2'd1);
    press_btn(20);
    wait_cyc(160);
    chk_val("edit_hold_sel", 32'(sel_d), 1);
    wait_drain(1, "edit_drain");
    edit_en = 1'b0;
    exp_q.push_back(2'd0);
    wait_drain(150, "edit_to_return");

    // Alarm from view 11
    for (int i = 1; i < 4; i++) begin
      exp_q.push_back(2'(i));
      press_btn(20);
    end
    wait_drain(5, "to_view_s");
    alarm_req = 1'b1;
    exp_q.push_back(2'd2);
    wait_cyc(1);
    chk_val("alm_sel", 32'(sel_d), 2);
    chk_val("alm_blink0", 32'(blink), 1);
    n = 0;
    while (blink == 1'b1 && n < 40) begin wait_cyc(1); n++; end
    chk_val("blink_first_ok", 32'(n >= 17 && n <= 20), 1);
    n = 0;
    while (blink == 1'b0 && n < 40) begin wait_cyc(1); n++; end
    chk_val("blink_lo_half", 32'(n), 20);
    n = 0;
    while (blink == 1'b1 && n < 40) begin wait_cyc(1); n++; end
    chk_val("blink_hi_half", 32'(n), 20);

    // Silence with press
    exp_q.push_back(2'd0);
    exp_ack++;
    press_btn(20);
    wait_drain(5, "ack_drain");
    chk_val("ack_count", 32'(ack_seen), 32'(exp_ack));
    wait_cyc(60);
    chk_val("no_reentry", 32'(sel_d), 0);
    alarm_req = 1'b0;
    wait_cyc(3);
    alarm_req = 1'b1;
    exp_q.push_back(2'd2);
    wait_drain(5, "rearm");
    chk_val("rearm_sel", 32'(sel_d), 2);
    alarm_req = 1'b0;
    exp_q.push_back(2'd0);
    wait_drain(5, "alm_fall");
    chk_val("fall_no_ack", 32'(ack_seen), 32'(exp_ack));

    // Alarm and press in the same cycle in view 00
    wait_cyc(10);
    btn_mode = 1'b1;
    n = 0;
    while (!m_press && n < 40) begin wait_cyc(1); n++; end
    if (n >= 40) chk_val("coll_wait", 32'(n), 0);
    alarm_req = 1'b1;
    exp_q.push_back(2'd2);
    wait_cyc(1);
    chk_val("coll_sel", 32'(sel_d), 2);
    wait_cyc(30);
    btn_mode = 1'b0;
    wait_cyc(20);
    chk_val("coll_hold_sel", 32'(sel_d), 2);
    chk_val("coll_no_ack", 32'(ack_seen), 32'(exp_ack));
    alarm_req = 1'b0;
    exp_q.push_back(2'd0);
    wait_drain(5, "coll_exit");

    // Asynchronous reset while in alarm during the dark blink phase
    alarm_req = 1'b1;
    exp_q.push_back(2'd2);
    wait_drain(5, "rst_alm_enter");
    wait_cyc(25);
    chk_val("pre_rst_blink", 32'(blink), 0);
    rst_n = 1'b0;
    #2;
    chk_val("arst_sel", 32'(sel_d), 0);
    chk_val("arst_blink", 32'(blink), 1);
    chk_val("arst_chg", 32'(view_chg), 0);
    chk_val("arst_ack", 32'(alarm_ack), 0);
    exp_q.push_back(2'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_drain(10, "rst_reenter");
    chk_val("reenter_sel", 32'(sel_d), 2);
    alarm_req = 1'b0;
    exp_q.push_back(2'd0);
    wait_drain(5, "final_exit");
    chk_val("final_ack", 32'(ack_seen), 32'(exp_ack));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
